// File: rtl/csa_accumulator.sv
// Carry-save signed accumulator: operands fold into S/C vectors with 3:2
// compression; a single carry-propagate add resolves each group's result.
module csa_accumulator #(
    parameter int W       = 16,
    parameter int MAX_OPS = 16,
    parameter int ACC_W   = W + $clog2(MAX_OPS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_data,
    input  logic                         in_sub,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_sum,
    output logic [$clog2(MAX_OPS+1)-1:0] out_count
);

    localparam int CNT_W = $clog2(MAX_OPS + 1);

    if (ACC_W < W + $clog2(MAX_OPS)) begin : g_acc_w_check
        $error("csa_accumulator: ACC_W too narrow for W and MAX_OPS");
    end
    if (MAX_OPS < 2) begin : g_max_ops_check
        $error("csa_accumulator: MAX_OPS must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ACC_W-1:0]   r_s;
    logic [ACC_W-1:0]   r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_sum;
    logic [CNT_W-1:0]   r_count;
    logic               r_live;
    logic               r_phase;

    logic               w_accept;
    logic               w_close;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [ACC_W-1:0]   w_ext;
    logic [ACC_W-1:0]   w_x;
    logic [ACC_W-1:0]   w_c_sh;
    logic [ACC_W-1:0]   w_s_nxt;
    logic [ACC_W-1:0]   w_c_nxt;
    logic [ACC_W-1:0]   w_total;

    assign in_ready  = r_live && (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_OUTPUT);
    assign out_sum   = r_sum;
    assign out_count = r_count;

    assign w_accept  = in_valid && in_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_close   = w_accept &&
                       (in_last || (w_cnt_inc == CNT_W'(MAX_OPS)));

    // Subtraction is ~x + 1; the +1 rides in the free LSB of the shifted carry.
    assign w_ext   = {{(ACC_W-W){in_data[W-1]}}, in_data};
    assign w_x     = in_sub ? ~w_ext : w_ext;
    assign w_c_sh  = {r_c[ACC_W-2:0], in_sub};
    assign w_s_nxt = r_s ^ w_c_sh ^ w_x;
    assign w_c_nxt = (r_s & w_c_sh) | (r_s & w_x) | (w_c_sh & w_x);

    assign w_total = r_s + {r_c[ACC_W-2:0], 1'b0};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_ACCUM:   if (w_close)   w_next = ST_RESOLVE;
            ST_RESOLVE: if (r_phase)   w_next = ST_OUTPUT;
            ST_OUTPUT:  if (out_ready) w_next = ST_ACCUM;
            default:                   w_next = ST_ACCUM;
        endcase
    end

    // RESOLVE spans two edges: capture the resolved sum, then present it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
            r_s     <= '0;
            r_c     <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_count <= '0;
            r_live  <= 1'b0;
            r_phase <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_next;
            if (w_accept) begin
                r_s   <= w_s_nxt;
                r_c   <= w_c_nxt;
                r_cnt <= w_cnt_inc;
            end
            if (r_state == ST_RESOLVE) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_sum   <= w_total;
                    r_count <= r_cnt;
                end
            end
            if ((r_state == ST_OUTPUT) && out_ready) begin
                r_s   <= '0;
                r_c   <= '0;
                r_cnt <= '0;
            end
        end
    end

endmodule
